stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 500000: clk cycles per tick, 100 Hz at 50 MHz; legal range DIV >= 2.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000: consecutive stable cycles to accept a key change, 20 ms; legal range DB_CYCLES >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port key_ss_n, input, 1 bit: start/stop push button, active-low, asynchronous to clk.
REQ-006 SHALL have port key_lap_n, input, 1 bit: lap/clear push button, active-low, asynchronous to clk.
REQ-007 SHALL have port tick, output, 1 bit: count strobe to the hundredths bcd_counter.
REQ-008 SHALL have port running, output, 1 bit: high while in RUN.
REQ-009 SHALL have port hold, output, 1 bit: display-freeze (lap) flag.
REQ-010 SHALL have port clr_n, output, 1 bit: active-low one-cycle clear pulse, ANDed externally with reset_n into the counter chain.

Function
REQ-011 SHALL pass each key through a 2-FF synchronizer whose flops reset to 1 (released).
REQ-012 SHALL debounce each synchronized key: the debounced level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any agreeing cycle clears that key's counter.
REQ-013 SHALL generate a one-cycle internal press event on each debounced 1->0 transition; releases SHALL generate no event.
REQ-014 SHALL implement FSM states IDLE (reset state), RUN and PAUSE.
REQ-015 SHALL on an ss press make the transitions IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-016 SHALL on a lap press toggle hold in RUN; in PAUSE, go to IDLE, clear hold and drive clr_n=0 for exactly one cycle; in IDLE, do nothing.
REQ-017 SHALL, when ss and lap press events occur in the same cycle, act on ss only and discard lap.
REQ-018 SHALL run the prescaler 0..DIV-1 only in cycles where the state is RUN: at DIV-1 it wraps to 0 and tick is registered to 1 for the next cycle; otherwise tick=0.
REQ-019 SHALL keep the prescaler value through PAUSE (no reset) and clear it to 0 in IDLE.
REQ-020 SHALL drive tick as a registered output, exactly one clk cycle high, glitch-free (the downstream counter uses it as an edge); tick SHALL never be high outside a post-RUN cycle.
REQ-021 SHALL make the first tick after IDLE->RUN occur DIV cycles after running rises.
REQ-022 SHALL keep tick generation unaffected by hold (the count continues while frozen).
REQ-023 SHALL drive running and clr_n from registers; hold SHALL persist across RUN<->PAUSE.

Reset
REQ-024 SHALL on reset_n=0 immediately set state=IDLE, prescaler=0, debounce counters=0, debounced levels=1, tick=0, running=0, hold=0, clr_n=1.
REQ-025 SHALL apply reset fully mid-operation, including mid-debounce and mid-prescale, with no pending event surviving it.
REQ-026 SHALL resume operation on the first clk edge after reset_n deasserts, with the keys treated as released.

Verification (DIV=4, DB_CYCLES=3)
REQ-027 Reset check: assert reset_n=0 with keys low -> all outputs at their REQ-024 values; release reset -> no press event until a key has been seen high then low.
REQ-028 Start: hold key_ss_n low 6 cycles -> running=1 after sync+debounce; tick pulses 1 cycle wide every 4 cycles, the first 4 cycles after running rises.
REQ-029 Bounce: key_ss_n low for 2 cycles then high -> no state change, running stays 0.
REQ-030 Pause/resume: ss press while prescaler=2 -> running=0, no ticks in PAUSE; ss press again -> next tick 2 RUN cycles later, then every 4.
REQ-031 Lap/clear: lap in RUN -> hold=1 with ticks continuing; lap again -> hold=0; ss then lap in PAUSE -> clr_n=0 for exactly 1 cycle, hold=0, IDLE, next start gives first tick after 4 cycles.
REQ-032 Simultaneous: ss and lap debounce in the same cycle during RUN -> PAUSE entered, hold unchanged, clr_n stays 1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control block for a hundredths-of-a-second stopwatch.
//
// Two push buttons drive a three-state machine (IDLE / RUN / PAUSE):
//   start/stop : IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   lap/clear  : RUN toggles the display-freeze flag, PAUSE clears back to
//                IDLE with a one-cycle clear pulse, IDLE ignores it
// A prescaler advances only in RUN and emits one registered tick every DIV
// RUN cycles. Its phase is kept across PAUSE, so a resumed run continues the
// partially elapsed hundredth.
//
// Parameters
//   DIV        clk cycles per tick (>= 2)
//   DB_CYCLES  consecutive stable cycles needed to accept a key change (>= 1)
//
// Ports
//   clk        system clock, all state on its rising edge
//   reset_n    asynchronous active-low reset
//   key_ss_n   start/stop button, active-low, asynchronous to clk
//   key_lap_n  lap/clear button, active-low, asynchronous to clk
//   tick       one-cycle count strobe to the hundredths counter
//   running    high while in RUN
//   hold       display-freeze (lap) flag
//   clr_n      active-low one-cycle clear pulse for the counter chain
module stopwatch_ctrl #(
    parameter int DIV       = 500000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_ss_n,
    input  logic key_lap_n,
    output logic tick,
    output logic running,
    output logic hold,
    output logic clr_n
);

    localparam int PW   = $clog2(DIV);
    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int K_SS  = 0;
    localparam int K_LAP = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Bit K_SS carries start/stop, bit K_LAP carries lap/clear.
    logic [1:0]           key_p0;
    logic [1:0]           key_p1;
    logic                 vld_p0;
    logic                 vld_p1;
    logic [1:0]           armed;
    logic [1:0]           db_lvl;
    logic [1:0][DBW-1:0]  db_cnt;
    logic [1:0]           db_done;
    logic [1:0]           press;

    state_t               state;
    state_t               state_nxt;
    logic                 hold_nxt;
    logic                 clr_n_nxt;
    logic [PW-1:0]        presc;

    // ---- stage p0/p1: two-flop synchronizer ----
    // vld_p0/vld_p1 mark when the synchronizer holds real samples rather
    // than its reset value, so a key held down across reset is not mistaken
    // for a fresh release followed by a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_p0 <= '1;
            key_p1 <= '1;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            key_p0 <= {key_lap_n, key_ss_n};
            key_p1 <= key_p0;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // ---- debounce and press detection ----
    // A press fires in the cycle the debounced level is about to fall, and
    // only once the key has genuinely been observed released since reset.
    always_comb begin
        db_done = '0;
        press   = '0;
        for (int k = 0; k < 2; k++) begin
            db_done[k] = (key_p1[k] != db_lvl[k]) &&
                         (db_cnt[k] == DBW'(DB_CYCLES - 1));
            press[k]   = db_done[k] && db_lvl[k] && armed[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_lvl <= '1;
            db_cnt <= '0;
            armed  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (vld_p1 && key_p1[k]) begin
                    armed[k] <= 1'b1;
                end
                if (key_p1[k] == db_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_done[k]) begin
                    db_lvl[k] <= key_p1[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // ---- control FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
            hold    <= 1'b0;
            clr_n   <= 1'b1;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
            hold    <= hold_nxt;
            clr_n   <= clr_n_nxt;
        end
    end

    // Start/stop wins when both keys fire together; lap is then dropped.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        clr_n_nxt = 1'b1;
        if (press[K_SS]) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end else if (press[K_LAP]) begin
            case (state)
                RUN: begin
                    hold_nxt = ~hold;
                end
                PAUSE: begin
                    state_nxt = IDLE;
                    hold_nxt  = 1'b0;
                    clr_n_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ---- prescaler and tick ----
    // Advances only during RUN cycles, frozen in PAUSE, zeroed in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (state == RUN) begin
                if (presc == PW'(DIV - 1)) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end else if (state == IDLE) begin
                presc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=4, DB_CYCLES=3.
// Per-cycle stimulus records carry the hand-derived expected outputs,
// packed as {running, hold, clr_n, tick}.
module tb_stopwatch_ctrl;

    logic clk       = 1'b0;
    logic reset_n   = 1'b1;
    logic key_ss_n  = 1'b0;
    logic key_lap_n = 1'b0;
    logic tick;
    logic running;
    logic hold;
    logic clr_n;

    int n_checks = 0;
    int n_errors = 0;
    int step     = 0;

    typedef struct {
        logic       ss;
        logic       lap;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_q[$];
    int         step_q[$];
    logic [3:0] mon_exp;
    int         mon_step;

    stopwatch_ctrl #(
        .DIV       (4),
        .DB_CYCLES (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_ss_n  (key_ss_n),
        .key_lap_n (key_lap_n),
        .tick      (tick),
        .running   (running),
        .hold      (hold),
        .clr_n     (clr_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: run/hold/clr_n/tick got %b required %b", name, got, want);
        end
    endtask

    function automatic void add(input logic ss, input logic lap, input int n, input logic [3:0] e);
        vec_t v;
        v.ss  = ss;
        v.lap = lap;
        v.n   = n;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    // Drives n cycles at the falling edge, queueing what the outputs must
    // read just after each following rising edge.
    task automatic run_seg(input logic ss, input logic lap, input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) begin
            key_ss_n  = ss;
            key_lap_n = lap;
            step++;
            exp_q.push_back(e);
            step_q.push_back(step);
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_step = step_q.pop_front();
            check($sformatf("cycle%0d", mon_step), {running, hold, clr_n, tick}, mon_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run/hold/clr_n/tick got timeout required completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        // keys held down through reset, then released, then bounced
        add(0, 0, 8, 4'b0010);
        add(1, 1, 8, 4'b0010);
        add(0, 1, 2, 4'b0010);
        add(1, 1, 8, 4'b0010);
        // start: running after sync+debounce, ticks every 4
        add(0, 1, 4, 4'b0010);
        add(0, 1, 2, 4'b1010);
        add(1, 1, 2, 4'b1010);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 1, 4'b1010);
        // lap in RUN sets hold, ticks continue
        add(1, 0, 2, 4'b1010);
        add(1, 0, 1, 4'b1011);
        add(1, 0, 1, 4'b1010);
        add(1, 1, 2, 4'b1110);
        add(1, 1, 1, 4'b1111);
        add(1, 1, 3, 4'b1110);
        // lap again clears hold
        add(1, 0, 1, 4'b1111);
        add(1, 0, 3, 4'b1110);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 3, 4'b1010);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 1, 4'b1010);
        // pause with prescaler frozen at 2
        add(0, 1, 2, 4'b1010);
        add(0, 1, 1, 4'b1011);
        add(0, 1, 1, 4'b1010);
        add(1, 1, 6, 4'b0010);
        // resume: first tick after 2 RUN cycles, then every 4
        add(0, 1, 4, 4'b0010);
        add(1, 1, 2, 4'b1010);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 1, 4'b1010);
        add(1, 0, 2, 4'b1010);
        add(1, 0, 1, 4'b1011);
        add(1, 0, 1, 4'b1010);
        add(1, 1, 2, 4'b1110);
        add(1, 1, 1, 4'b1111);
        add(1, 1, 3, 4'b1110);
        // simultaneous ss+lap: pause, hold kept, no clear
        add(0, 0, 1, 4'b1111);
        add(0, 0, 3, 4'b1110);
        add(1, 1, 1, 4'b0111);
        add(1, 1, 5, 4'b0110);
        // lap in PAUSE: one-cycle clear, back to IDLE
        add(1, 0, 4, 4'b0110);
        add(1, 1, 1, 4'b0000);
        add(1, 1, 5, 4'b0010);
        // lap in IDLE does nothing
        add(1, 0, 4, 4'b0010);
        add(1, 1, 2, 4'b0010);
        // fresh start: first tick 4 cycles after running rises
        add(0, 1, 4, 4'b0010);
        add(1, 1, 4, 4'b1010);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 3, 4'b1010);
        add(1, 1, 1, 4'b1011);
        add(1, 1, 3, 4'b1010);

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {running, hold, clr_n, tick}, 4'b0010);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_seg(tbl[i].ss, tbl[i].lap, tbl[i].n, tbl[i].exp);
        end

        // reset mid-prescale and mid-debounce of a pending ss press
        run_seg(0, 1, 1, 4'b1011);
        run_seg(0, 1, 1, 4'b1010);
        @(posedge clk);
        #3;
        reset_n  = 1'b0;
        key_ss_n = 1'b1;
        #1;
        check("async_reset", {running, hold, clr_n, tick}, 4'b0010);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_seg(1, 1, 10, 4'b0010);
        // operation resumes normally after reset
        run_seg(0, 1, 4, 4'b0010);
        run_seg(1, 1, 4, 4'b1010);
        run_seg(1, 1, 1, 4'b1011);
        run_seg(1, 1, 1, 4'b1010);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
